// File: rtl/ddr3_frame_slot_scheduler.sv
// Frame-slot allocator for the DDR3 frame buffer.
// Tracks each slot through FREE/WRITING/READY/READING for one writer and one reader.
module ddr3_frame_slot_scheduler #(
  parameter int          NUM_SLOTS   = 4,
  parameter logic [26:0] SLOT_BASE   = 27'h1800000,
  parameter logic [26:0] SLOT_STRIDE = 27'h0100000
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        sof,
  input  logic        frame_done,
  output logic        wr_start,
  output logic [2:0]  wr_slot,
  output logic [26:0] wr_base_addr,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [2:0]  rd_slot,
  output logic [26:0] rd_base_addr,
  input  logic        rd_release,
  output logic        frame_avail,
  output logic [15:0] frame_count,
  output logic [7:0]  drop_count,
  output logic [7:0]  overrun_count,
  output logic        seq_err
);

  typedef enum logic [1:0] {
    S_FREE, S_WRITING, S_READY, S_READING
  } slot_st_e;

  typedef enum logic {
    WR_IDLE, WR_ACTIVE
  } wr_st_e;

  slot_st_e   slot_q [NUM_SLOTS];
  slot_st_e   slot_d [NUM_SLOTS];
  wr_st_e     wr_q;
  logic       sof_d;

  logic       sof_edge;
  logic       has_free;
  logic [2:0] free_idx;
  logic       has_ready;
  logic [2:0] ready_idx;
  logic       has_reading;
  logic       done;
  logic       abandon;
  logic       alloc;
  logic       grant;
  logic       release_ok;
  logic       ready_nxt;

  assign sof_edge   = sof & ~sof_d;
  assign done       = frame_done & (wr_q == WR_ACTIVE);
  assign abandon    = sof_edge & ~frame_done & (wr_q == WR_ACTIVE);
  assign alloc      = sof_edge & has_free;
  assign grant      = rd_req & ~has_reading & has_ready;
  assign release_ok = rd_release & has_reading;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    has_free    = 1'b0;
    free_idx    = '0;
    has_ready   = 1'b0;
    ready_idx   = '0;
    has_reading = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_q[i] == S_FREE) begin
        has_free = 1'b1;
        free_idx = 3'(i);
      end
      if (slot_q[i] == S_READY) begin
        has_ready = 1'b1;
        ready_idx = 3'(i);
      end
      if (slot_q[i] == S_READING)
        has_reading = 1'b1;
    end
  end

  // Every transition below acts on a distinct pre-cycle state,
  // so the updates never collide on the same slot.
  always_comb begin
    ready_nxt = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        S_READING: if (release_ok) slot_d[i] = S_FREE;
        S_READY: begin
          if (grant)     slot_d[i] = S_READING;
          else if (done) slot_d[i] = S_FREE;
        end
        S_WRITING: begin
          if (done)         slot_d[i] = S_READY;
          else if (abandon) slot_d[i] = S_FREE;
        end
        default: if (alloc && free_idx == 3'(i)) slot_d[i] = S_WRITING;
      endcase
      if (slot_d[i] == S_READY)
        ready_nxt = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        slot_q[i] <= S_FREE;
      wr_q          <= WR_IDLE;
      sof_d         <= 1'b1;
      wr_start      <= 1'b0;
      wr_slot       <= '0;
      rd_ack        <= 1'b0;
      rd_slot       <= '0;
      frame_avail   <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
      overrun_count <= '0;
      seq_err       <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      sof_d       <= sof;
      wr_start    <= alloc;
      rd_ack      <= grant;
      frame_avail <= ready_nxt;
      if (alloc)
        wr_slot <= free_idx;
      if (grant)
        rd_slot <= ready_idx;
      if (sof_edge)
        wr_q <= has_free ? WR_ACTIVE : WR_IDLE;
      else if (done)
        wr_q <= WR_IDLE;
      if (done)
        frame_count <= frame_count + 16'd1;
      if (sof_edge && !has_free && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (abandon && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
      if ((frame_done && wr_q == WR_IDLE) ||
          (rd_release && !has_reading))
        seq_err <= 1'b1;
    end
  end

  assign wr_base_addr = SLOT_BASE + 27'(wr_slot) * SLOT_STRIDE;
  assign rd_base_addr = SLOT_BASE + 27'(rd_slot) * SLOT_STRIDE;

endmodule

// File: tb/tb_ddr3_frame_slot_scheduler.sv
// Directed bench for ddr3_frame_slot_scheduler.
// A 4-slot and a 2-slot instance share one stimulus stream.
module tb_ddr3_frame_slot_scheduler;

  logic        pclk = 1'b0;
  logic        reset, sof, frame_done, rd_req, rd_release;
  logic        wr_start, rd_ack, frame_avail, seq_err;
  logic [2:0]  wr_slot, rd_slot;
  logic [26:0] wr_base_addr, rd_base_addr;
  logic [15:0] frame_count;
  logic [7:0]  drop_count, overrun_count;

  logic        b_wr_start, b_rd_ack, b_frame_avail, b_seq_err;
  logic [2:0]  b_wr_slot, b_rd_slot;
  logic [26:0] b_wr_base_addr, b_rd_base_addr;
  logic [15:0] b_frame_count;
  logic [7:0]  b_drop_count, b_overrun_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  ddr3_frame_slot_scheduler dut (
    .pclk(pclk), .reset(reset), .sof(sof),
    .frame_done(frame_done), .wr_start(wr_start),
    .wr_slot(wr_slot), .wr_base_addr(wr_base_addr),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_slot(rd_slot),
    .rd_base_addr(rd_base_addr), .rd_release(rd_release),
    .frame_avail(frame_avail), .frame_count(frame_count),
    .drop_count(drop_count), .overrun_count(overrun_count),
    .seq_err(seq_err)
  );

  ddr3_frame_slot_scheduler #(.NUM_SLOTS(2)) dut2 (
    .pclk(pclk), .reset(reset), .sof(sof),
    .frame_done(frame_done), .wr_start(b_wr_start),
    .wr_slot(b_wr_slot), .wr_base_addr(b_wr_base_addr),
    .rd_req(rd_req), .rd_ack(b_rd_ack), .rd_slot(b_rd_slot),
    .rd_base_addr(b_rd_base_addr), .rd_release(rd_release),
    .frame_avail(b_frame_avail), .frame_count(b_frame_count),
    .drop_count(b_drop_count), .overrun_count(b_overrun_count),
    .seq_err(b_seq_err)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic done_pulse();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rel_pulse();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  initial begin
    sof = 1'b0;
    frame_done = 1'b0;
    rd_req = 1'b0;
    rd_release = 1'b0;
    do_reset();

    chk("rst_wr_start", 32'(wr_start), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_wr_slot", 32'(wr_slot), 32'd0);
    chk("rst_wr_base", 32'(wr_base_addr), 32'h1800000);
    chk("rst_rd_base", 32'(rd_base_addr), 32'h1800000);
    chk("rst_avail", 32'(frame_avail), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);

    // three frames, no reader: slots 0,1,0
    sof_pulse();
    chk("f1_wr_start", 32'(wr_start), 32'd1);
    chk("f1_wr_slot", 32'(wr_slot), 32'd0);
    tick();
    chk("f1_start_pulse", 32'(wr_start), 32'd0);
    done_pulse();
    chk("f1_avail", 32'(frame_avail), 32'd1);
    sof_pulse();
    chk("f2_wr_slot", 32'(wr_slot), 32'd1);
    chk("f2_wr_base", 32'(wr_base_addr), 32'h1900000);
    done_pulse();
    sof_pulse();
    chk("f3_wr_slot", 32'(wr_slot), 32'd0);
    done_pulse();
    chk("f3_fcount", 32'(frame_count), 32'd3);
    chk("f3_avail", 32'(frame_avail), 32'd1);

    // reader holds slot 0 while slots 1 and 2 complete
    rd_pulse();
    chk("g0_ack", 32'(rd_ack), 32'd1);
    chk("g0_slot", 32'(rd_slot), 32'd0);
    tick();
    chk("g0_ack_pulse", 32'(rd_ack), 32'd0);
    sof_pulse();
    chk("h1_wr_slot", 32'(wr_slot), 32'd1);
    done_pulse();
    sof_pulse();
    chk("h2_wr_slot", 32'(wr_slot), 32'd2);
    chk("h2_wr_base", 32'(wr_base_addr), 32'h1A00000);
    done_pulse();
    chk("h2_rd_hold", 32'(rd_slot), 32'd0);
    rd_pulse();
    chk("busy_req_ignored", 32'(rd_ack), 32'd0);
    rel_pulse();
    rd_pulse();
    chk("g2_ack", 32'(rd_ack), 32'd1);
    chk("g2_slot", 32'(rd_slot), 32'd2);
    chk("g2_rd_base", 32'(rd_base_addr), 32'h1A00000);
    chk("g2_avail", 32'(frame_avail), 32'd0);
    chk("g2_fcount", 32'(frame_count), 32'd5);
    tick();

    // overrun: second sof before frame_done
    sof_pulse();
    chk("o0_wr_slot", 32'(wr_slot), 32'd0);
    tick();
    sof_pulse();
    chk("o1_wr_start", 32'(wr_start), 32'd1);
    chk("o1_wr_slot", 32'(wr_slot), 32'd1);
    chk("o1_overrun", 32'(overrun_count), 32'd1);
    done_pulse();
    sof_pulse();
    chk("o2_slot0_free", 32'(wr_slot), 32'd0);

    // grant and completion in the same cycle
    rel_pulse();
    rd_req = 1'b1;
    frame_done = 1'b1;
    tick();
    rd_req = 1'b0;
    frame_done = 1'b0;
    chk("gc_ack", 32'(rd_ack), 32'd1);
    chk("gc_rd_slot", 32'(rd_slot), 32'd1);
    chk("gc_avail", 32'(frame_avail), 32'd1);
    chk("gc_fcount", 32'(frame_count), 32'd7);
    sof_pulse();
    chk("gc_slot1_held", 32'(wr_slot), 32'd2);
    done_pulse();
    chk("pre_seq_err", 32'(seq_err), 32'd0);

    // sequence errors
    done_pulse();
    chk("idle_done_err", 32'(seq_err), 32'd1);
    chk("idle_done_fcount", 32'(frame_count), 32'd8);
    chk("idle_done_avail", 32'(frame_avail), 32'd1);
    do_reset();
    chk("rst2_seq_err", 32'(seq_err), 32'd0);
    chk("rst2_fcount", 32'(frame_count), 32'd0);
    rel_pulse();
    chk("rel_err", 32'(seq_err), 32'd1);
    tick();
    tick();
    chk("rel_err_sticky", 32'(seq_err), 32'd1);
    chk("rel_avail", 32'(frame_avail), 32'd0);

    // two-slot instance: drop when nothing is free
    do_reset();
    sof_pulse();
    chk("b_w0_slot", 32'(b_wr_slot), 32'd0);
    done_pulse();
    rd_pulse();
    chk("b_g0_ack", 32'(b_rd_ack), 32'd1);
    sof_pulse();
    chk("b_w1_slot", 32'(b_wr_slot), 32'd1);
    done_pulse();
    sof_pulse();
    chk("b_drop_no_start", 32'(b_wr_start), 32'd0);
    tick();
    chk("b_drop_count", 32'(b_drop_count), 32'd1);
    chk("b_drop_overrun", 32'(b_overrun_count), 32'd0);
    chk("b_drop_slot_hold", 32'(b_wr_slot), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
